game_ctl: RTL
=============

GAME_CTL -- requirements
Module: game_ctl

Interface
REQ-001 Parameter LIVES, default 3, lives granted at game start (1..3).
REQ-002 Parameter BOTTOM_Y, default 740, ball y at or beyond which the ball is lost.
REQ-003 Parameter SERVE_FRAMES, default 60, frames the ball is held before each serve.
REQ-004 Parameter OVER_FRAMES, default 120, frames a click is ignored after win or loss.
REQ-005 pclk  in  1  pixel clock, sole clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 vsync_in  in  1  vertical sync from the timing chain; its rising edge is the frame tick.
REQ-008 mouse_left  in  1  left button from the mouse controller; asynchronous to pclk.
REQ-009 ball_y  in  12  current ball y position.
REQ-010 collision_det  in  1  block-hit indication; each rising edge is one hit.
REQ-011 blocks_in  in  16  block-alive bitmap; 1 = block present.
REQ-012 ball_run  out  1  ball motion enable.
REQ-013 ball_rst  out  1  one-cycle pulse that re-centres the ball on the paddle.
REQ-014 blocks_load  out  1  one-cycle pulse that restores all 16 blocks.
REQ-015 state  out  3  current state code.
REQ-016 lives  out  2  remaining lives.
REQ-017 score  out  8  blocks destroyed in the current game.

Function
REQ-018 mouse_left shall pass a 2-flop synchronizer; a click is a registered 0->1 edge of the synchronized signal. Latency is 3 cycles from the input change.
REQ-019 The frame tick and the hit event shall be registered 0->1 edges of vsync_in and collision_det, each one cycle wide.
REQ-020 States and codes: IDLE=0, SERVE=1, PLAY=2, MISS=3, LOST=4, WON=5. Codes 6 and 7 shall go to IDLE.
REQ-021 IDLE: ball_run=0. A click shall go to SERVE and, in the same cycle, load lives=LIVES, clear score, and pulse blocks_load and ball_rst.
REQ-022 SERVE: ball_run=0. The frame counter shall clear on entry and count ticks. The tick that makes the count equal SERVE_FRAMES shall go to PLAY.
REQ-023 PLAY: ball_run=1. If blocks_in==0, go to WON. Otherwise, if ball_y>=BOTTOM_Y, go to MISS. WON takes priority over MISS in the same cycle.
REQ-024 PLAY: each hit event shall increment score, saturating at 255. A hit in the same cycle as the transition to WON shall still be counted.
REQ-025 MISS is exactly one cycle with ball_run=0. It decrements lives. If lives was 1, go to LOST with lives=0. Otherwise go to SERVE and pulse ball_rst.
REQ-026 LOST/WON: ball_run=0 and score is frozen. The frame counter clears on entry. Clicks are ignored until OVER_FRAMES ticks have elapsed. After that, a click shall go to IDLE.
REQ-027 Hit events outside PLAY shall be ignored. A click outside IDLE/LOST/WON shall be ignored.
REQ-028 The frame counter shall be 8 bits and shall saturate at 255. It shall not wrap.
REQ-029 All outputs shall be registered. ball_rst and blocks_load shall never be high for more than one consecutive cycle.

Reset
REQ-030 On reset low, outputs shall immediately take: state=IDLE, ball_run=0, ball_rst=0, blocks_load=0, lives=0, score=0. Synchronizer, edge, and counter registers shall clear to 0.
REQ-031 Reset asserted in any state, including mid-serve or mid-miss, shall abort the state with no pending pulse. After release, the block stays in IDLE until the first click.

Structure
REQ-032 Package arcanoid_pkg shall hold the state codes, score width (8), frame-counter width (8), and the defaults for LIVES, BOTTOM_Y, SERVE_FRAMES and OVER_FRAMES.
REQ-033 A single sub-module, edge_det, shall be used. It has an optional 2-flop synchronizer and a registered rising-edge pulse output, and is instantiated three times (mouse_left synchronized, vsync_in, collision_det).

Verification
REQ-034 Reset release, click -> SERVE after 3 cycles, with blocks_load, ball_rst and score=0 pulsed in the same cycle. 60 vsync edges -> PLAY with ball_run=1.
REQ-035 PLAY, LIVES=3, ball_y=740 -> MISS for 1 cycle, then lives=2 and SERVE. Repeat twice -> LOST with lives=0. Clicks in the next 119 frames are ignored; a click after 120 frames -> IDLE.
REQ-036 PLAY, blocks_in=0 and ball_y=745 in the same cycle -> WON. lives and score are unchanged.
REQ-037 PLAY, 300 collision_det pulses -> score=255 (saturated). A held-high collision_det counts once. Pulses in SERVE leave score unchanged.
REQ-038 Reset low during SERVE frame 30 -> all outputs at reset values with no clock edge. After release, a 1-cycle mouse_left glitch shorter than the synchronizer sampling gives no state change.

Source files
------------

// File: rtl/arcanoid_pkg.sv
// Shared types and defaults for the arcanoid game controller.
// The state codes are visible on the state output, so their values are fixed.
package arcanoid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_MISS  = 3'd3,
      ST_LOST  = 3'd4,
      ST_WON   = 3'd5
   } state_t;

   localparam int SCORE_W = 8;
   localparam int FCNT_W  = 8;

   localparam int LIVES_DEF        = 3;
   localparam int BOTTOM_Y_DEF     = 740;
   localparam int SERVE_FRAMES_DEF = 60;
   localparam int OVER_FRAMES_DEF  = 120;

   // Score and frame counter share this width; both stick at all-ones.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector with optional 2-flop synchronizer.
// The pulse is a flop output, one pclk cycle wide per 0->1 transition.
module edge_det #(
   parameter bit SYNC = 1'b0
) (
   input  logic pclk,
   input  logic reset,
   input  logic d,
   output logic pulse
);

   logic d_s;
   logic prev_q;

   generate
      if (SYNC) begin : g_sync
         logic [1:0] sync_q;
         always_ff @(posedge pclk or negedge reset) begin
            if (!reset) sync_q <= 2'b00;
            else        sync_q <= {sync_q[0], d};
         end
         assign d_s = sync_q[1];
      end else begin : g_direct
         assign d_s = d;
      end
   endgenerate

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         prev_q <= d_s;
         pulse  <= d_s & ~prev_q;
      end
   end

endmodule

// File: rtl/game_ctl.sv
// Arcanoid game flow controller: serve, play, miss, win/loss and score.
// Every output is a flop written by the single FSM process below.
module game_ctl
   import arcanoid_pkg::*;
#(
   parameter int LIVES        = LIVES_DEF,
   parameter int BOTTOM_Y     = BOTTOM_Y_DEF,
   parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
   parameter int OVER_FRAMES  = OVER_FRAMES_DEF
) (
   input  logic               pclk,
   input  logic               reset,
   input  logic               vsync_in,
   input  logic               mouse_left,
   input  logic [11:0]        ball_y,
   input  logic               collision_det,
   input  logic [15:0]        blocks_in,
   output logic               ball_run,
   output logic               ball_rst,
   output logic               blocks_load,
   output logic [2:0]         state,
   output logic [1:0]         lives,
   output logic [SCORE_W-1:0] score
);

   localparam logic [11:0]       BOTTOM_C = 12'(BOTTOM_Y);
   localparam logic [1:0]        LIVES_C  = 2'(LIVES);
   localparam logic [FCNT_W-1:0] SERVE_C  = FCNT_W'(SERVE_FRAMES);
   localparam logic [FCNT_W-1:0] OVER_C   = FCNT_W'(OVER_FRAMES);

   logic              click;
   logic              tick;
   logic              hit;
   state_t            state_q;
   logic [FCNT_W-1:0] frame_cnt;

   edge_det #(.SYNC(1'b1)) u_click (.pclk(pclk), .reset(reset), .d(mouse_left),    .pulse(click));
   edge_det #(.SYNC(1'b0)) u_tick  (.pclk(pclk), .reset(reset), .d(vsync_in),      .pulse(tick));
   edge_det #(.SYNC(1'b0)) u_hit   (.pclk(pclk), .reset(reset), .d(collision_det), .pulse(hit));

   assign state = state_q;

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         ball_run    <= 1'b0;
         ball_rst    <= 1'b0;
         blocks_load <= 1'b0;
         lives       <= 2'd0;
         score       <= '0;
         frame_cnt   <= '0;
      end else begin
         // Pulses default low so they can never stretch past one cycle.
         ball_rst    <= 1'b0;
         blocks_load <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               ball_run <= 1'b0;
               if (click) begin
                  state_q     <= ST_SERVE;
                  lives       <= LIVES_C;
                  score       <= '0;
                  frame_cnt   <= '0;
                  ball_rst    <= 1'b1;
                  blocks_load <= 1'b1;
               end
            end

            ST_SERVE: begin
               ball_run <= 1'b0;
               if (tick) begin
                  frame_cnt <= sat_inc(frame_cnt);
                  if (sat_inc(frame_cnt) == SERVE_C) begin
                     state_q  <= ST_PLAY;
                     ball_run <= 1'b1;
                  end
               end
            end

            ST_PLAY: begin
               ball_run <= 1'b1;
               if (hit) score <= sat_inc(score);
               if (blocks_in == 16'd0) begin
                  state_q   <= ST_WON;
                  ball_run  <= 1'b0;
                  frame_cnt <= '0;
               end else if (ball_y >= BOTTOM_C) begin
                  state_q  <= ST_MISS;
                  ball_run <= 1'b0;
               end
            end

            ST_MISS: begin
               ball_run  <= 1'b0;
               frame_cnt <= '0;
               if (lives <= 2'd1) begin
                  state_q <= ST_LOST;
                  lives   <= 2'd0;
               end else begin
                  state_q  <= ST_SERVE;
                  lives    <= lives - 2'd1;
                  ball_rst <= 1'b1;
               end
            end

            ST_LOST, ST_WON: begin
               ball_run <= 1'b0;
               if (tick) frame_cnt <= sat_inc(frame_cnt);
               if (click && frame_cnt >= OVER_C) state_q <= ST_IDLE;
            end

            default: begin
               state_q  <= ST_IDLE;
               ball_run <= 1'b0;
            end
         endcase
      end
   end

endmodule
